// File: rtl/ctrl_pipeline.sv
// Control pipeline from ID through WB: carries decoder bundles and register specifiers, and handles load-use/RAW stalls and branch/jump flushes.
// Optional build macro CTRL_PIPELINE_FORWARD_EN adds fwd_a/fwd_b forwarding selects and keeps only the load-use stall.
module ctrl_pipeline #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_ex,
  input  logic [3:0]       id_m,
  input  logic [1:0]       id_wb,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             pc_src,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dst,
  output logic             stall,
  output logic             flush
`ifdef CTRL_PIPELINE_FORWARD_EN
  ,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`endif
);

  // Bit positions inside the decoder bundles.
  localparam int EX_REG_DST  = 3;
  localparam int EX_ALU_SRC  = 0;
  localparam int M_BRANCH    = 3;
  localparam int M_MEM_READ  = 2;
  localparam int M_MEM_WRITE = 1;
  localparam int M_JUMP      = 0;
  localparam int WB_REG_WR   = 1;
  localparam int WB_MEM2REG  = 0;

  typedef struct packed {
    logic [3:0]       ex;
    logic [3:0]       m;
    logic [1:0]       wb;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic [3:0]       m;
    logic [1:0]       wb;
    logic [REG_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic [1:0]       wb;
    logic [REG_W-1:0] dst;
  } memwb_t;

  idex_t            r_idex;
  exmem_t           r_exmem;
  memwb_t           r_memwb;
  idex_t            w_cap;
  logic [REG_W-1:0] w_ex_dst;
  logic             w_load_use;
  logic             w_stall_raw;

  // NOTE: every variable written in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_cap = '0;
    if (id_valid) begin
      w_cap.ex = id_ex;
      w_cap.m  = id_m;
      w_cap.wb = id_wb;
      w_cap.rt = id_rt;
      w_cap.rd = id_rd;
      if (!id_wb[WB_REG_WR]) begin
        w_cap.ex[EX_REG_DST] = 1'b0;
        w_cap.wb[WB_MEM2REG] = 1'b0;
      end
      if (id_m[M_BRANCH] || id_m[M_JUMP]) begin
        w_cap.m[M_MEM_READ]  = 1'b0;
        w_cap.m[M_MEM_WRITE] = 1'b0;
      end
    end
  end

  assign w_ex_dst = r_idex.ex[EX_REG_DST] ? r_idex.rd : r_idex.rt;

  assign w_load_use = r_idex.m[M_MEM_READ] && (r_idex.rt != '0) && id_valid &&
                      ((r_idex.rt == id_rs) || (r_idex.rt == id_rt));

`ifdef CTRL_PIPELINE_FORWARD_EN
  logic [REG_W-1:0] r_ex_rs;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input exmem_t em, input memwb_t mw);
    if (em.wb[WB_REG_WR] && (em.dst != '0) && (em.dst == src))
      return 2'b10;
    else if (mw.wb[WB_REG_WR] && (mw.dst != '0) && (mw.dst == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush || stall || !id_valid)
      r_ex_rs <= '0;
    else
      r_ex_rs <= id_rs;
  end

  assign fwd_a       = fwd_sel(r_ex_rs, r_exmem, r_memwb);
  assign fwd_b       = fwd_sel(r_idex.rt, r_exmem, r_memwb);
  assign w_stall_raw = w_load_use;
`else
  // Without forwarding, a source waits until its producer has reached WB; the register file writes before it reads.
  function automatic logic src_hit(input logic [REG_W-1:0] src,
                                   input logic ex_wr, input logic [REG_W-1:0] ex_dst,
                                   input logic mem_wr, input logic [REG_W-1:0] mem_dst);
    return (src != '0) && ((ex_wr && (ex_dst == src)) || (mem_wr && (mem_dst == src)));
  endfunction

  logic w_raw_hazard;
  assign w_raw_hazard = id_valid &&
    (src_hit(id_rs, r_idex.wb[WB_REG_WR], w_ex_dst, r_exmem.wb[WB_REG_WR], r_exmem.dst) ||
     src_hit(id_rt, r_idex.wb[WB_REG_WR], w_ex_dst, r_exmem.wb[WB_REG_WR], r_exmem.dst));
  assign w_stall_raw = w_load_use || w_raw_hazard;
`endif

  assign pc_src = (r_exmem.m[M_BRANCH] && mem_zero) || r_exmem.m[M_JUMP];
  assign flush  = pc_src;
  assign stall  = w_stall_raw && !pc_src;

  // NOTE: sequential state uses non-blocking assignments so each stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_memwb <= '{wb: r_exmem.wb, dst: r_exmem.dst};
      if (flush) begin
        r_idex  <= '0;
        r_exmem <= '0;
      end else begin
        r_exmem <= '{m: r_idex.m, wb: r_idex.wb, dst: w_ex_dst};
        r_idex  <= stall ? '0 : w_cap;
      end
    end
  end

  assign ex_reg_dst    = r_idex.ex[EX_REG_DST];
  assign ex_alu_op     = r_idex.ex[2:1];
  assign ex_alu_src    = r_idex.ex[EX_ALU_SRC];
  assign mem_read      = r_exmem.m[M_MEM_READ];
  assign mem_write     = r_exmem.m[M_MEM_WRITE];
  assign wb_reg_write  = r_memwb.wb[WB_REG_WR];
  assign wb_mem_to_reg = r_memwb.wb[WB_MEM2REG];
  assign wb_dst        = r_memwb.dst;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline in its default build (forwarding macro undefined): each step drives the next
// ID bundle, then compares the packed output word against a hand-computed value.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_ex, id_m;
  logic [1:0] id_wb;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mem_zero;
  logic       ex_reg_dst, ex_alu_src, mem_read, mem_write, pc_src;
  logic       wb_reg_write, wb_mem_to_reg, stall, flush;
  logic [1:0] ex_alu_op;
  logic [4:0] wb_dst;
`ifdef CTRL_PIPELINE_FORWARD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  ctrl_pipeline #(.REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .pc_src(pc_src),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .stall(stall), .flush(flush)
`ifdef CTRL_PIPELINE_FORWARD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  // {ex_reg_dst, ex_alu_op, ex_alu_src} {mem_read, mem_write, pc_src} {flush, stall} {wb_reg_write, wb_mem_to_reg} wb_dst
  logic [15:0] obs;
  assign obs = {ex_reg_dst, ex_alu_op, ex_alu_src, mem_read, mem_write, pc_src,
                flush, stall, wb_reg_write, wb_mem_to_reg, wb_dst};

  task automatic check(input string tag, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed ex=%b mem=%b fs=%b wb=%b dst=%0d, expected ex=%b mem=%b fs=%b wb=%b dst=%0d",
             tag, obs[15:12], obs[11:9], obs[8:7], obs[6:5], obs[4:0],
             exp[15:12], exp[11:9], exp[8:7], exp[6:5], exp[4:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ex, input logic [3:0] m, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_ex = ex; id_m = m; id_wb = wb;
    id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  // Decoder bundles: R-type ex=1100 wb=10; lw ex=0001 m=0100 wb=11; sw ex=0001 m=0010; beq ex=0010 m=1000; j m=0001.
  initial begin
    rst_n = 1'b0;
    mem_zero = 1'b0;
    drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd5);

    // Reset held with an R-type presented.
    tick(); check("rst_edge1", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("rst_edge2", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    rst_n = 1'b1;
    tick(); nop(); check("rtype_ex",  {4'b1100, 3'b000, 2'b00, 2'b00, 5'd0});
    tick();        check("rtype_mem", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick();        check("rtype_wb",  {4'b0000, 3'b000, 2'b00, 2'b10, 5'd5});
    tick();        check("rtype_gone", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});

    // Capture sanitising: invalid slot, RegWrite=0 with RegDst/MemtoReg set, sw, branch with MemRead/MemWrite set.
    drive(1'b0, 4'b1111, 4'b0100, 2'b11, 5'd0, 5'd0, 5'd0);
    tick(); drive(1'b1, 4'b1110, 4'b0000, 2'b01, 5'd0, 5'd0, 5'd9);
    check("invalid_bubble", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); drive(1'b1, 4'b0001, 4'b0010, 2'b00, 5'd0, 5'd0, 5'd0);
    check("rw0_regdst_aluop11", {4'b0110, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); drive(1'b1, 4'b0010, 4'b1110, 2'b00, 5'd0, 5'd0, 5'd0);
    check("sw_ex", {4'b0001, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); nop();
    check("sw_mem_rw0_wb", {4'b0010, 3'b010, 2'b00, 2'b00, 5'd0});
    tick(); check("branch_nottaken_sanitised", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("branch_wb", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});

    // Load-use: lw rt=8 then add rs=8. The default build also stalls while the load sits in EX/MEM,
    // so the add is held two cycles and enters EX once the load is in WB.
    drive(1'b1, 4'b0001, 4'b0100, 2'b11, 5'd0, 5'd8, 5'd0);
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd8, 5'd0, 5'd9);
    check("loaduse_stall", {4'b0001, 3'b000, 2'b01, 2'b00, 5'd0});
    tick(); check("loaduse_bubble_ex", {4'b0000, 3'b100, 2'b01, 2'b00, 5'd0});
    tick(); check("load_wb", {4'b0000, 3'b000, 2'b00, 2'b11, 5'd8});
    tick(); nop();
    check("add_after_load_ex", {4'b1100, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("bubble_in_wb", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("add9_wb", {4'b0000, 3'b000, 2'b00, 2'b10, 5'd9});

    // RAW without forwarding: add r3 then sub rs=3 holds for two cycles.
    drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd3);
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd3, 5'd0, 5'd4);
    check("raw_stall_ex", {4'b1100, 3'b000, 2'b01, 2'b00, 5'd0});
    tick(); check("raw_stall_mem", {4'b0000, 3'b000, 2'b01, 2'b00, 5'd0});
    tick(); check("raw_release_wb3", {4'b0000, 3'b000, 2'b00, 2'b10, 5'd3});
    // Destination 0 is never a hazard source.
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd0);
    check("sub_ex", {4'b1100, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd6);
    check("dst0_no_stall", {4'b1100, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); nop();
    check("sub4_wb", {4'b1100, 3'b000, 2'b00, 2'b10, 5'd4});
    tick(); check("dst0_wb", {4'b0000, 3'b000, 2'b00, 2'b10, 5'd0});
    tick(); check("sub6_wb", {4'b0000, 3'b000, 2'b00, 2'b10, 5'd6});
    tick(); check("drain", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});

    // Taken branch: beq then two younger R-types; both younger bundles get cleared.
    mem_zero = 1'b1;
    drive(1'b1, 4'b0010, 4'b1000, 2'b00, 5'd0, 5'd0, 5'd0);
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd10);
    check("beq_ex", {4'b0010, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd11);
    check("beq_taken", {4'b1100, 3'b001, 2'b10, 2'b00, 5'd0});
    tick(); nop();
    check("beq_flushed", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("young1_wb_cleared", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("young2_wb_cleared", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    mem_zero = 1'b0;

    // Jump in MEM while a load-use pair sits in EX/ID: flush wins, stall is suppressed.
    drive(1'b1, 4'b0000, 4'b0001, 2'b00, 5'd0, 5'd0, 5'd0);
    tick(); drive(1'b1, 4'b0001, 4'b0100, 2'b11, 5'd0, 5'd6, 5'd0);
    check("jump_ex", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd6, 5'd0, 5'd12);
    check("jump_flush_over_stall", {4'b0001, 3'b001, 2'b10, 2'b00, 5'd0});
    tick(); nop();
    check("jump_wb_zero", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("flushed_load_gone", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});

    // Reset mid-stream discards in-flight control.
    drive(1'b1, 4'b0001, 4'b0100, 2'b11, 5'd0, 5'd7, 5'd0);
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd13);
    check("lw7_ex", {4'b0001, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); drive(1'b1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd14);
    check("add13_ex_lw_mem", {4'b1100, 3'b100, 2'b00, 2'b00, 5'd0});
    tick(); check("add14_ex_lw_wb", {4'b1100, 3'b000, 2'b00, 2'b11, 5'd7});
    rst_n = 1'b0;
    tick(); check("midreset", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    rst_n = 1'b1;
    nop();
    tick(); check("postreset1", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});
    tick(); check("postreset2", {4'b0000, 3'b000, 2'b00, 2'b00, 5'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
